// File: rtl/dvi_rx_channel.sv
// Receive side of one DVI TMDS channel: finds 10-bit symbol alignment from
// control-token runs in blanking and decodes each aligned symbol.
module dvi_rx_channel #(
    parameter int unsigned LOCK_COUNT     = 64,
    parameter int unsigned SEARCH_TIMEOUT = 2048,
    parameter int unsigned LOSS_TIMEOUT   = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] raw,
    input  logic       resync,
    output logic       locked,
    output logic [3:0] offset,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    localparam int unsigned SYM_W  = 10;
    localparam int unsigned WIN_W  = 2 * SYM_W;
    localparam int unsigned OFF_W  = 4;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned DATA_W = 8;

    localparam int unsigned MAX_A     = (LOCK_COUNT > SEARCH_TIMEOUT) ? LOCK_COUNT : SEARCH_TIMEOUT;
    localparam int unsigned MAX_LIMIT = (MAX_A > LOSS_TIMEOUT) ? MAX_A : LOSS_TIMEOUT;
    localparam int unsigned CNT_W     = (MAX_LIMIT > 2) ? $clog2(MAX_LIMIT) : 1;

    localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(LOCK_COUNT - 1);
    localparam logic [CNT_W-1:0] SEARCH_LAST = CNT_W'(SEARCH_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    localparam logic [OFF_W-1:0] OFF_MAX     = OFF_W'(9);
    localparam logic [1:0]       SETTLE_INIT = 2'd2;

    localparam logic [SYM_W-1:0] TOK_00 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_01 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_10 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_11 = 10'h2AB;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [SYM_W-1:0]   r_cur, r_prev, sym;
    logic [CNT_W-1:0]   run_cnt, run_nxt;
    logic [CNT_W-1:0]   gap_cnt, gap_nxt;
    logic [1:0]         settle_cnt, settle_nxt;
    logic [OFF_W-1:0]   offset_nxt;

    logic [WIN_W-1:0]   window_c;
    logic [SEL_W-1:0]   sel_c;
    logic               is_ctl_c;
    logic [1:0]         tok_ctrl_c;
    logic [DATA_W-1:0]  dec_word_c;
    logic [DATA_W-1:0]  dec_data_c;

    logic               de_nxt;
    logic [1:0]         ctrl_nxt;
    logic [DATA_W-1:0]  data_nxt;

    // Older word in the low half so window bits run in arrival order.
    assign window_c = {r_cur, r_prev};
    assign sel_c    = SEL_W'(offset);

    // Token match and TMDS data decode of the aligned symbol.
    always_comb begin
        is_ctl_c   = 1'b1;
        tok_ctrl_c = 2'b00;
        dec_data_c = '0;
        case (sym)
            TOK_00:  tok_ctrl_c = 2'b00;
            TOK_01:  tok_ctrl_c = 2'b01;
            TOK_10:  tok_ctrl_c = 2'b10;
            TOK_11:  tok_ctrl_c = 2'b11;
            default: is_ctl_c   = 1'b0;
        endcase
        dec_word_c    = sym[9] ? ~sym[7:0] : sym[7:0];
        dec_data_c[0] = dec_word_c[0];
        for (int i = 1; i < int'(DATA_W); i++) begin
            dec_data_c[i] = sym[8] ? (dec_word_c[i] ^ dec_word_c[i-1])
                                   : ~(dec_word_c[i] ^ dec_word_c[i-1]);
        end
    end

    // Alignment hunt / lock supervision next-state logic.
    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        run_nxt    = run_cnt;
        gap_nxt    = gap_cnt;
        settle_nxt = settle_cnt;
        if (resync) begin
            state_nxt = ST_SEARCH;
            run_nxt   = '0;
            gap_nxt   = '0;
        end else begin
            case (state)
                ST_SEARCH: begin
                    if (settle_cnt != 2'd0) begin
                        // Symbols still in flight were cut at the previous offset.
                        settle_nxt = settle_cnt - 2'd1;
                    end else if (is_ctl_c) begin
                        gap_nxt = '0;
                        if (run_cnt >= RUN_LAST) begin
                            state_nxt = ST_LOCKED;
                            run_nxt   = '0;
                        end else begin
                            run_nxt = run_cnt + CNT_ONE;
                        end
                    end else begin
                        run_nxt = '0;
                        if (gap_cnt >= SEARCH_LAST) begin
                            offset_nxt = (offset == OFF_MAX) ? '0 : offset + OFF_W'(1);
                            gap_nxt    = '0;
                            settle_nxt = SETTLE_INIT;
                        end else begin
                            gap_nxt = gap_cnt + CNT_ONE;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (is_ctl_c) begin
                        gap_nxt = '0;
                    end else if (gap_cnt >= LOSS_LAST) begin
                        state_nxt = ST_SEARCH;
                        gap_nxt   = '0;
                        run_nxt   = '0;
                    end else begin
                        gap_nxt = gap_cnt + CNT_ONE;
                    end
                end
                default: state_nxt = ST_SEARCH;
            endcase
        end
    end

    // Output stage: blank until locked; ctrl holds through active video.
    always_comb begin
        de_nxt   = 1'b0;
        ctrl_nxt = 2'b00;
        data_nxt = '0;
        if (locked) begin
            if (is_ctl_c) begin
                ctrl_nxt = tok_ctrl_c;
            end else begin
                de_nxt   = 1'b1;
                ctrl_nxt = ctrl;
                data_nxt = dec_data_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cur      <= '0;
            r_prev     <= '0;
            sym        <= '0;
            state      <= ST_SEARCH;
            locked     <= 1'b0;
            offset     <= '0;
            run_cnt    <= '0;
            gap_cnt    <= '0;
            settle_cnt <= '0;
            de         <= 1'b0;
            ctrl       <= 2'b00;
            data       <= '0;
        end else begin
            r_cur      <= raw;
            r_prev     <= r_cur;
            sym        <= window_c[sel_c +: SYM_W];
            state      <= state_nxt;
            locked     <= (state_nxt == ST_LOCKED);
            offset     <= offset_nxt;
            run_cnt    <= run_nxt;
            gap_cnt    <= gap_nxt;
            settle_cnt <= settle_nxt;
            de         <= de_nxt;
            ctrl       <= ctrl_nxt;
            data       <= data_nxt;
        end
    end

endmodule

// File: tb/tb_dvi_rx_channel.sv
// Directed bench for dvi_rx_channel: rotated TMDS streams from a reference
// encoder, lock/loss thresholds, token decode, resync and async reset.
module tb_dvi_rx_channel;

    localparam logic [9:0] TOK0 = 10'h354;
    localparam logic [9:0] D00  = 10'h100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] raw;
    logic       resync;
    logic       locked;
    logic [3:0] offset;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;

    int         errors = 0;
    int         checks = 0;
    int         rot    = 0;
    int         disp   = 0;
    logic [9:0] prev_sym = '0;

    logic [9:0]  ctl_vec [8] = '{10'h354, 10'h1FF, 10'h0AB, 10'h0FF,
                                 10'h154, 10'h155, 10'h2AB, 10'h2AA};
    logic [10:0] ctl_exp [8] = '{11'h000, 11'h401, 11'h100, 11'h5FF,
                                 11'h200, 11'h6FF, 11'h300, 11'h701};

    dvi_rx_channel dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (raw),
        .resync (resync),
        .locked (locked),
        .offset (offset),
        .de     (de),
        .ctrl   (ctrl),
        .data   (data)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serialize symbols LSB first and present a 10-bit window skipped by rot bits.
    task automatic step(input logic [9:0] s);
        logic [19:0] pair;
        pair = {s, prev_sym};
        raw  = (rot == 0) ? s : pair[5'(rot) +: 10];
        prev_sym = s;
        @(posedge clk);
        #1;
    endtask

    // Reference DVI TMDS encoder with running disparity.
    task automatic tmds_enc(input logic [7:0] d, output logic [9:0] q);
        logic [8:0] qm;
        int         n1d, n1, n0;
        logic       xn;
        n1d   = $countones(d);
        xn    = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = ~xn;
        n1 = $countones(qm[7:0]);
        n0 = 8 - n1;
        if (disp == 0 || n1 == n0) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8]) disp = disp + n1 - n0;
            else       disp = disp + n0 - n1;
        end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            disp = disp + (qm[8] ? 2 : 0) + n0 - n1;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            disp = disp - (qm[8] ? 0 : 2) + n1 - n0;
        end
    endtask

    task automatic do_reset();
        resync   = 1'b0;
        raw      = '0;
        prev_sym = '0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       ever;
        logic [9:0] s;
        int         n;

        rst_n  = 1'b1;
        raw    = '0;
        resync = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_state", 32'({locked, offset, de, ctrl, data}), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 63-token runs never lock; a 64-token run locks 3 steps after the last token.
        rot  = 0;
        ever = 1'b0;
        repeat (3) begin
            repeat (63) begin step(TOK0); if (locked) ever = 1'b1; end
            repeat (8)  begin step(D00);  if (locked) ever = 1'b1; end
        end
        check_eq("thr63_nolock", 32'(ever), 32'd0);
        repeat (64) step(TOK0);
        step(D00);
        step(D00);
        check_eq("thr64_early", 32'(locked), 32'd0);
        step(D00);
        check_eq("thr64_lock", 32'(locked), 32'd1);
        check_eq("thr64_off", 32'(offset), 32'd0);

        // Rotation sweep: offsets 0,1..9 via rotations 0,9..1.
        do_reset();
        for (int idx = 0; idx < 10; idx++) begin
            if (idx > 0) begin
                resync = 1'b1;
                step(D00);
                resync = 1'b0;
                rot = 10 - idx;
                n   = 0;
                while (offset == 4'(idx - 1) && n < 2200) begin
                    step(D00);
                    n++;
                end
                check_eq("sweep_adv", 32'(offset), 32'(idx));
            end
            disp = 0;
            for (int j = 0; j < 843; j++) begin
                if (j < 200 || j >= 840) s = TOK0;
                else tmds_enc(8'((j - 200) % 256), s);
                step(s);
                if (j == 200) begin
                    check_eq("sweep_lock", 32'(locked), 32'd1);
                    check_eq("sweep_off", 32'(offset), 32'(idx));
                end
                if (j >= 203) check_eq("sweep_data", 32'({de, data}), 32'({1'b1, 8'((j - 203) % 256)}));
            end
        end

        // Search advance with rotation 3: step at 2048, then every 2050 cycles.
        do_reset();
        rot = 3;
        for (int k = 1; k <= 14348; k++) begin
            step(D00);
            if (k == 2047)  check_eq("adv_off0", 32'(offset), 32'd0);
            if (k == 2048)  check_eq("adv_off1", 32'(offset), 32'd1);
            if (k == 14347) check_eq("adv_off6", 32'(offset), 32'd6);
            if (k == 14348) check_eq("adv_off7", 32'(offset), 32'd7);
        end
        repeat (100) step(TOK0);
        check_eq("adv_lock", 32'(locked), 32'd1);
        check_eq("adv_lock_off", 32'(offset), 32'd7);

        // Token and data decode while locked; outputs trail input by 3 steps.
        for (int i = 0; i < 11; i++) begin
            step((i < 8) ? ctl_vec[i] : TOK0);
            if (i >= 3) check_eq("ctl_dec", 32'({de, ctrl, data}), 32'(ctl_exp[i-3]));
        end

        // Loss of lock on the 4096th data symbol, then relock.
        repeat (4098) step(D00);
        check_eq("loss_early", 32'(locked), 32'd1);
        step(D00);
        check_eq("loss_drop", 32'(locked), 32'd0);
        check_eq("loss_off", 32'(offset), 32'd7);
        repeat (66) step(TOK0);
        check_eq("relock_early", 32'(locked), 32'd0);
        step(TOK0);
        check_eq("relock", 32'(locked), 32'd1);

        // resync drops lock on the next cycle, offset retained.
        resync = 1'b1;
        step(TOK0);
        resync = 1'b0;
        check_eq("resync_lock", 32'(locked), 32'd0);
        check_eq("resync_off", 32'(offset), 32'd7);

        // Asynchronous reset mid-frame.
        repeat (70) step(TOK0);
        check_eq("prerst_lock", 32'(locked), 32'd1);
        repeat (5) step(10'h0FF);
        check_eq("prerst_data", 32'({de, data}), 32'h1FF);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst", 32'({locked, offset, de, ctrl, data}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
